flag_branch_resolver: RTL and testbench

- Consumer end of the ALU flag interface: holds the architectural N/Z/V flag register written by the saturating adder/ALU.
- Tracks flag-writing instructions still in flight.
- Resolves conditional branches against the correct (bypassed) flags, stalling via a valid/ready handshake until all older flag writers have written back.
- Sits between decode (branch requests) and EX/writeback (flag results).

---
 rtl/wisc_pkg.sv | 27 ++
 rtl/branch_cond_eval.sv | 33 +++
 rtl/flag_branch_resolver.sv | 121 ++++++++++++
 tb/tb_flag_branch_resolver.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
// Shared definitions for the flag interface: condition codes, flag bit
// positions and the branch resolver state encoding.
package wisc_pkg;

  localparam int unsigned FLAG_W = 3;
  localparam int unsigned CCC_W  = 3;

  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [CCC_W-1:0] CCC_NE     = 3'd0;
  localparam logic [CCC_W-1:0] CCC_EQ     = 3'd1;
  localparam logic [CCC_W-1:0] CCC_GT     = 3'd2;
  localparam logic [CCC_W-1:0] CCC_LT     = 3'd3;
  localparam logic [CCC_W-1:0] CCC_GE     = 3'd4;
  localparam logic [CCC_W-1:0] CCC_LE     = 3'd5;
  localparam logic [CCC_W-1:0] CCC_OVF    = 3'd6;
  localparam logic [CCC_W-1:0] CCC_UNCOND = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESOLVE = 2'd2
  } br_state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Evaluates a branch condition code against an {N,Z,V} flag vector.
// Purely combinational so the fetch-stage predictor check can share it.
module branch_cond_eval
  import wisc_pkg::*;
(
  input  logic [CCC_W-1:0]  ccc,
  input  logic [FLAG_W-1:0] flags,
  output logic              taken
);

  logic n;
  logic z;
  logic v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];

  always_comb begin
    taken = 1'b0;
    case (ccc)
      CCC_NE:     taken = ~z;
      CCC_EQ:     taken = z;
      CCC_GT:     taken = ~z & ~n;
      CCC_LT:     taken = n;
      CCC_GE:     taken = z | (~z & ~n);
      CCC_LE:     taken = n | z;
      CCC_OVF:    taken = v;
      CCC_UNCOND: taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/flag_branch_resolver.sv
// Architectural N/Z/V flag register plus in-flight flag-writer tracking;
// resolves conditional branches once every older flag writer has written back.
module flag_branch_resolver
  import wisc_pkg::*;
#(
  parameter int unsigned MAX_PENDING = 3,
  parameter int unsigned CNT_W       = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fw_issue,
  input  logic              fw_wb,
  input  logic [FLAG_W-1:0] fw_mask,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_v,
  input  logic              br_valid,
  input  logic [CCC_W-1:0]  br_ccc,
  output logic              br_ready,
  output logic              res_valid,
  output logic              res_taken,
  output logic [FLAG_W-1:0] flags,
  output logic              cnt_err
);

  br_state_t         state;
  logic [CCC_W-1:0]  ccc_q;
  logic [CNT_W-1:0]  pend_cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              cnt_ovf_c;
  logic              cnt_unf_c;
  logic [FLAG_W-1:0] alu_flags;
  logic [FLAG_W-1:0] flags_next;
  logic [CCC_W-1:0]  ccc_sel;
  logic              taken_c;
  logic              drained_c;

  // Per-bit writeback merge; this value also feeds branch evaluation as a bypass.
  always_comb begin
    alu_flags         = '0;
    alu_flags[FLAG_N] = alu_n;
    alu_flags[FLAG_Z] = alu_z;
    alu_flags[FLAG_V] = alu_v;
  end

  assign flags_next = fw_wb ? ((flags & ~fw_mask) | (alu_flags & fw_mask)) : flags;

  // Pending writer count saturates at both ends and flags the attempt.
  always_comb begin
    cnt_next  = pend_cnt;
    cnt_ovf_c = 1'b0;
    cnt_unf_c = 1'b0;
    if (fw_issue && !fw_wb) begin
      if (pend_cnt == CNT_W'(MAX_PENDING)) cnt_ovf_c = 1'b1;
      else                                 cnt_next  = pend_cnt + CNT_W'(1);
    end else if (fw_wb && !fw_issue) begin
      if (pend_cnt == '0) cnt_unf_c = 1'b1;
      else                cnt_next  = pend_cnt - CNT_W'(1);
    end
  end

  assign drained_c = (cnt_next == '0);

  // In IDLE the incoming code is evaluated directly so a branch can resolve on acceptance.
  assign ccc_sel  = (state == ST_IDLE) ? br_ccc : ccc_q;
  assign br_ready = (state == ST_IDLE);

  branch_cond_eval u_cond (
    .ccc   (ccc_sel),
    .flags (flags_next),
    .taken (taken_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags    <= '0;
      pend_cnt <= '0;
      cnt_err  <= 1'b0;
    end else begin
      flags    <= flags_next;
      pend_cnt <= cnt_next;
      cnt_err  <= cnt_err | cnt_ovf_c | cnt_unf_c;
    end
  end

  // Branch FSM; res_valid is a one-cycle strobe registered alongside RESOLVE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ccc_q     <= '0;
      res_valid <= 1'b0;
      res_taken <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (br_valid) begin
            ccc_q <= br_ccc;
            if (drained_c) begin
              res_taken <= taken_c;
              res_valid <= 1'b1;
              state     <= ST_RESOLVE;
            end else begin
              state     <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (drained_c) begin
            res_taken <= taken_c;
            res_valid <= 1'b1;
            state     <= ST_RESOLVE;
          end
        end
        ST_RESOLVE: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flag_branch_resolver.sv
// Self-checking bench for flag_branch_resolver: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_flag_branch_resolver;

  localparam int MAXP = 3;

  logic       clk;
  logic       rst_n;
  logic       fw_issue;
  logic       fw_wb;
  logic [2:0] fw_mask;
  logic       alu_n;
  logic       alu_z;
  logic       alu_v;
  logic       br_valid;
  logic [2:0] br_ccc;
  logic       br_ready;
  logic       res_valid;
  logic       res_taken;
  logic [2:0] flags;
  logic       cnt_err;

  int errors;
  int checks;

  // Behavioural model state
  logic [2:0] m_flags;
  int         m_pend;
  logic       m_err;
  int         m_phase;   // 0 free, 1 branch waiting on writers, 2 result being presented
  logic [2:0] m_ccc;
  logic       m_taken;

  flag_branch_resolver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fw_issue  (fw_issue),
    .fw_wb     (fw_wb),
    .fw_mask   (fw_mask),
    .alu_n     (alu_n),
    .alu_z     (alu_z),
    .alu_v     (alu_v),
    .br_valid  (br_valid),
    .br_ccc    (br_ccc),
    .br_ready  (br_ready),
    .res_valid (res_valid),
    .res_taken (res_taken),
    .flags     (flags),
    .cnt_err   (cnt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic cond(input logic [2:0] c, input logic [2:0] f);
    logic n, z, v;
    n = f[2]; z = f[1]; v = f[0];
    case (c)
      3'd0:    return !z;
      3'd1:    return z;
      3'd2:    return !z && !n;
      3'd3:    return n;
      3'd4:    return z || (!z && !n);
      3'd5:    return n || z;
      3'd6:    return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_flags = 3'b000; m_pend = 0; m_err = 1'b0;
    m_phase = 0; m_ccc = 3'b000; m_taken = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic [2:0] fn;
    logic [2:0] a;
    int c;
    a  = {alu_n, alu_z, alu_v};
    fn = m_flags;
    if (fw_wb)
      for (int i = 0; i < 3; i++) if (fw_mask[i]) fn[i] = a[i];
    c = m_pend + (fw_issue ? 1 : 0) - (fw_wb ? 1 : 0);
    if (c < 0)    begin c = 0;    m_err = 1'b1; end
    if (c > MAXP) begin c = MAXP; m_err = 1'b1; end
    if (m_phase == 0) begin
      if (br_valid) begin
        m_ccc = br_ccc;
        if (c == 0) begin m_taken = cond(br_ccc, fn); m_phase = 2; end
        else m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (c == 0) begin m_taken = cond(m_ccc, fn); m_phase = 2; end
    end else begin
      m_phase = 0;
    end
    m_flags = fn;
    m_pend  = c;
  endtask

  task automatic cycle(input logic iss, input logic wb, input logic [2:0] mask,
                       input logic [2:0] alu, input logic bv, input logic [2:0] ccc);
    fw_issue = iss; fw_wb = wb; fw_mask = mask;
    alu_n = alu[2]; alu_z = alu[1]; alu_v = alu[0];
    br_valid = bv; br_ccc = ccc;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    fw_issue = 1'b0; fw_wb = 1'b0; fw_mask = 3'b000;
    alu_n = 1'b0; alu_z = 1'b0; alu_v = 1'b0;
    br_valid = 1'b0; br_ccc = 3'b000;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (flags !== 3'b000)  begin errors++; $display("FAIL reset_flags: got %b want 000", flags); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    checks++; if (res_taken !== 1'b0) begin errors++; $display("FAIL reset_res_taken: got %b want 0", res_taken); end
    checks++; if (cnt_err !== 1'b0)   begin errors++; $display("FAIL reset_cnt_err: got %b want 0", cnt_err); end
    checks++; if (br_ready !== 1'b1)  begin errors++; $display("FAIL reset_br_ready: got %b want 1", br_ready); end
  endtask

  task automatic test_uncond();
    apply_reset();
    cycle(1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 3'b111);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL uncond_valid: got %b want 1", res_valid); end
    checks++; if (res_taken !== 1'b1) begin errors++; $display("FAIL uncond_taken: got %b want 1", res_taken); end
    checks++; if (flags !== 3'b000)   begin errors++; $display("FAIL uncond_flags: got %b want 000", flags); end
    checks++; if (br_ready !== 1'b0)  begin errors++; $display("FAIL uncond_ready_in_resolve: got %b want 0", br_ready); end
    idle();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL uncond_strobe_width: got %b want 0", res_valid); end
    checks++; if (br_ready !== 1'b1)  begin errors++; $display("FAIL uncond_back_idle: got %b want 1", br_ready); end
  endtask

  task automatic test_bypass();
    apply_reset();
    cycle(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000);
    cycle(1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 3'b001);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL bypass_wait_valid: got %b want 0", res_valid); end
    checks++; if (br_ready !== 1'b0)  begin errors++; $display("FAIL bypass_wait_ready: got %b want 0", br_ready); end
    cycle(1'b0, 1'b1, 3'b111, 3'b010, 1'b0, 3'b000);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bypass_valid: got %b want 1", res_valid); end
    checks++; if (res_taken !== 1'b1) begin errors++; $display("FAIL bypass_taken: got %b want 1", res_taken); end
    checks++; if (flags !== 3'b010)   begin errors++; $display("FAIL bypass_flags: got %b want 010", flags); end
    idle();
    checks++; if (res_taken !== 1'b1) begin errors++; $display("FAIL bypass_taken_hold: got %b want 1", res_taken); end
  endtask

  task automatic test_flag_merge();
    apply_reset();
    cycle(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000);
    cycle(1'b0, 1'b1, 3'b111, 3'b100, 1'b0, 3'b000);
    checks++; if (flags !== 3'b100) begin errors++; $display("FAIL merge_set_n: got %b want 100", flags); end
    cycle(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000);
    cycle(1'b0, 1'b1, 3'b010, 3'b011, 1'b0, 3'b000);
    checks++; if (flags !== 3'b110) begin errors++; $display("FAIL merge_z_only: got %b want 110", flags); end
    cycle(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000);
    cycle(1'b0, 1'b1, 3'b000, 3'b001, 1'b0, 3'b000);
    checks++; if (flags !== 3'b110) begin errors++; $display("FAIL merge_mask_zero: got %b want 110", flags); end
    cycle(1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 3'b011);
    checks++; if (res_valid !== 1'b1 || res_taken !== 1'b1) begin
      errors++; $display("FAIL merge_lt: got valid=%b taken=%b want valid=1 taken=1", res_valid, res_taken);
    end
    idle();
    cycle(1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 3'b010);
    checks++; if (res_valid !== 1'b1 || res_taken !== 1'b0) begin
      errors++; $display("FAIL merge_gt: got valid=%b taken=%b want valid=1 taken=0", res_valid, res_taken);
    end
    checks++; if (cnt_err !== 1'b0) begin errors++; $display("FAIL merge_no_err: got %b want 0", cnt_err); end
  endtask

  task automatic test_cnt_sat();
    apply_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000);
    checks++; if (cnt_err !== 1'b0) begin errors++; $display("FAIL sat_no_err_at_max: got %b want 0", cnt_err); end
    cycle(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000);
    checks++; if (cnt_err !== 1'b1) begin errors++; $display("FAIL sat_overflow_err: got %b want 1", cnt_err); end
    cycle(1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 3'b000);
    cycle(1'b0, 1'b1, 3'b000, 3'b000, 1'b1, 3'b111);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL sat_one_left_waits: got %b want 0", res_valid); end
    cycle(1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 3'b000);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL sat_drain_resolves: got %b want 1", res_valid); end
    checks++; if (cnt_err !== 1'b1)   begin errors++; $display("FAIL sat_err_sticky: got %b want 1", cnt_err); end
    apply_reset();
    cycle(1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 3'b000);
    checks++; if (cnt_err !== 1'b1) begin errors++; $display("FAIL underflow_err: got %b want 1", cnt_err); end
    cycle(1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 3'b111);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL underflow_holds_zero: got %b want 1", res_valid); end
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    cycle(1'b0, 1'b1, 3'b111, 3'b111, 1'b0, 3'b000);
    cycle(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000);
    cycle(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000);
    cycle(1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 3'b000);
    checks++; if (br_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_wait: got %b want 0", br_ready); end
    br_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (br_ready !== 1'b1)  begin errors++; $display("FAIL midrst_ready: got %b want 1", br_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", res_valid); end
    checks++; if (flags !== 3'b000)   begin errors++; $display("FAIL midrst_flags: got %b want 000", flags); end
    checks++; if (cnt_err !== 1'b0)   begin errors++; $display("FAIL midrst_cnt_err: got %b want 0", cnt_err); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_late_valid[%0d]: got %b want 0", i, res_valid); end
    end
  endtask

  task automatic test_issue_wb_same();
    apply_reset();
    cycle(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000);
    cycle(1'b1, 1'b1, 3'b000, 3'b000, 1'b1, 3'b111);
    checks++; if (res_valid !== 1'b0 || br_ready !== 1'b0) begin
      errors++; $display("FAIL same_cycle_wait: got valid=%b ready=%b want valid=0 ready=0", res_valid, br_ready);
    end
    idle();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL same_cycle_still_wait: got %b want 0", res_valid); end
    cycle(1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 3'b000);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL same_cycle_resolve: got %b want 1", res_valid); end
    checks++; if (cnt_err !== 1'b0)   begin errors++; $display("FAIL same_cycle_no_err: got %b want 0", cnt_err); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    cycle(1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 3'b000);
    checks++; if (res_valid !== 1'b1 || res_taken !== 1'b1) begin
      errors++; $display("FAIL b2b_first: got valid=%b taken=%b want valid=1 taken=1", res_valid, res_taken);
    end
    cycle(1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 3'b001);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL b2b_not_accepted_in_resolve: got %b want 0", res_valid); end
    cycle(1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 3'b001);
    checks++; if (res_valid !== 1'b1 || res_taken !== 1'b0) begin
      errors++; $display("FAIL b2b_second: got valid=%b taken=%b want valid=1 taken=0", res_valid, res_taken);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), 3'($urandom),
            3'($urandom), 1'($urandom), 3'($urandom));
      checks++; if (res_valid !== (m_phase == 2)) begin errors++; $display("FAIL rand_valid[%0d]: got %b want %b", i, res_valid, (m_phase == 2)); end
      checks++; if (br_ready !== (m_phase == 0))  begin errors++; $display("FAIL rand_ready[%0d]: got %b want %b", i, br_ready, (m_phase == 0)); end
      checks++; if (res_taken !== m_taken)        begin errors++; $display("FAIL rand_taken[%0d]: got %b want %b", i, res_taken, m_taken); end
      checks++; if (flags !== m_flags)            begin errors++; $display("FAIL rand_flags[%0d]: got %b want %b", i, flags, m_flags); end
      checks++; if (cnt_err !== m_err)            begin errors++; $display("FAIL rand_cnt_err[%0d]: got %b want %b", i, cnt_err, m_err); end
      if (i == 199) apply_reset();
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    test_reset();
    test_uncond();
    test_bypass();
    test_flag_merge();
    test_cnt_sat();
    test_reset_mid_wait();
    test_issue_wb_same();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
